// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared widths, slot record and latency helper for the AR/R responder
// Purpose : common definitions imported by axi_read_responder.
// Contents: ID_W/SEQ_W/CNT_W/OLD_W widths, rd_slot_t slot record,
//           calc_latency() giving the fixed per-ID response delay.
package axi_rd_pkg;

   localparam int ID_W  = 4;
   localparam int SEQ_W = 8;
   localparam int CNT_W = 8;
   // Holds a count of older same-ID slots; DEPTH is at most 16 so 15 fits with margin.
   localparam int OLD_W = 5;

   typedef struct packed {
      logic             valid;
      logic [ID_W-1:0]  id;
      logic [SEQ_W-1:0] seq;
      logic [CNT_W-1:0] cnt;
      logic [OLD_W-1:0] older;
   } rd_slot_t;

   // Higher IDs answer faster: base + (15 - id) * step, clamped to the counter range.
   function automatic logic [CNT_W-1:0] calc_latency(input logic [ID_W-1:0] id,
                                                     input int lat_base,
                                                     input int lat_step);
      int lat;
      lat = lat_base + (((1 << ID_W) - 1) - int'(id)) * lat_step;
      if (lat > 255) lat = 255;
      return CNT_W'(lat);
   endfunction

endpackage

// File: rtl/rd_slot_picker.sv
// rtl/rd_slot_picker.sv - combinational lowest-index-first selector
// Purpose : returns the lowest set position of a request vector.
// Ports   : i_req   [N-1:0]     request/eligible vector
//           o_idx   [IDX_W-1:0] index of lowest set bit (0 when none)
//           o_found             at least one bit set
module rd_slot_picker #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   // Scan downwards so the last hit written is the lowest index.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = IDX_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - out-of-order AR/R read target with per-ID latency
// Purpose : accepts read requests into DEPTH slots and returns one R beat per
//           request after a fixed per-ID delay, same-ID beats kept in issue order.
//           R data carries the 8-bit issue sequence number of the request.
// Ports   : clk, rst (async, active high)
//           s_arid_i, s_arvalid_i, s_arready_o          request channel
//           s_rdata_o, s_rid_o, s_rvalid_o, s_rready_i  response channel
module axi_read_responder
   import axi_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int LAT_BASE   = 2,
   parameter int LAT_STEP   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       s_arid_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [ID_W-1:0]       s_rid_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i
);

   localparam int IDX_W = $clog2(DEPTH);

   rd_slot_t              r_slot [DEPTH];
   logic [SEQ_W-1:0]      r_seq;
   logic                  r_rvalid;
   logic [ID_W-1:0]       r_rid;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [DEPTH-1:0]      w_valid;
   logic [DEPTH-1:0]      w_elig;
   logic [IDX_W-1:0]      w_alloc_idx;
   logic [IDX_W-1:0]      w_issue_idx;
   logic                  w_alloc_found;
   logic                  w_issue_found;
   logic                  w_ar_fire;
   logic                  w_load_en;
   logic                  w_issue;
   logic [ID_W-1:0]       w_issue_id;
   logic [OLD_W-1:0]      w_new_older;

   always_comb begin
      w_valid = '0;
      w_elig  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_valid[k] = r_slot[k].valid;
         // A slot leaves only when its delay has elapsed and no older same-ID slot remains.
         w_elig[k]  = r_slot[k].valid && (r_slot[k].cnt == '0) && (r_slot[k].older == '0);
      end
   end

   rd_slot_picker #(.N(DEPTH), .IDX_W(IDX_W)) u_alloc (
      .i_req   (~w_valid),
      .o_idx   (w_alloc_idx),
      .o_found (w_alloc_found)
   );

   rd_slot_picker #(.N(DEPTH), .IDX_W(IDX_W)) u_issue (
      .i_req   (w_elig),
      .o_idx   (w_issue_idx),
      .o_found (w_issue_found)
   );

   // Occupancy is the registered valid vector, so a slot freed this cycle is reused next cycle.
   assign s_arready_o = !rst && w_alloc_found;
   assign w_ar_fire   = s_arvalid_i && s_arready_o;
   assign w_load_en   = !r_rvalid || s_rready_i;
   assign w_issue     = w_load_en && w_issue_found;
   assign w_issue_id  = r_slot[w_issue_idx].id;

   // Older count for a new entry ignores a same-ID slot that is leaving this same cycle.
   always_comb begin
      w_new_older = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_slot[k].valid && (r_slot[k].id == s_arid_i) &&
             !(w_issue && (IDX_W'(k) == w_issue_idx)))
            w_new_older = w_new_older + OLD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
         r_seq    <= '0;
         r_rvalid <= 1'b0;
         r_rid    <= '0;
         r_rdata  <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (r_slot[k].valid) begin
               if (r_slot[k].cnt != '0) r_slot[k].cnt <= r_slot[k].cnt - CNT_W'(1);
               if (w_issue && (r_slot[k].id == w_issue_id) && (IDX_W'(k) != w_issue_idx) &&
                   (r_slot[k].older != '0))
                  r_slot[k].older <= r_slot[k].older - OLD_W'(1);
            end
         end

         if (w_issue) begin
            r_slot[w_issue_idx].valid <= 1'b0;
            r_rvalid <= 1'b1;
            r_rid    <= w_issue_id;
            r_rdata  <= DATA_WIDTH'(r_slot[w_issue_idx].seq);
         end else if (w_load_en) begin
            r_rvalid <= 1'b0;
         end

         if (w_ar_fire) begin
            r_slot[w_alloc_idx].valid <= 1'b1;
            r_slot[w_alloc_idx].id    <= s_arid_i;
            r_slot[w_alloc_idx].seq   <= r_seq;
            r_slot[w_alloc_idx].cnt   <= calc_latency(s_arid_i, LAT_BASE, LAT_STEP);
            r_slot[w_alloc_idx].older <= w_new_older;
            r_seq <= r_seq + SEQ_W'(1);
         end
      end
   end

   assign s_rvalid_o = r_rvalid;
   assign s_rid_o    = r_rid;
   assign s_rdata_o  = r_rdata;

endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - self-checking bench for axi_read_responder
module tb_axi_read_responder;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 4;
   localparam int LAT_BASE   = 2;
   localparam int LAT_STEP   = 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [3:0]            s_arid_i = '0;
   logic                  s_arvalid_i = 1'b0;
   logic                  s_arready_o;
   logic [DATA_WIDTH-1:0] s_rdata_o;
   logic [3:0]            s_rid_o;
   logic                  s_rvalid_o;
   logic                  s_rready_i = 1'b0;

   axi_read_responder #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .LAT_BASE   (LAT_BASE),
      .LAT_STEP   (LAT_STEP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_arid_i    (s_arid_i),
      .s_arvalid_i (s_arvalid_i),
      .s_arready_o (s_arready_o),
      .s_rdata_o   (s_rdata_o),
      .s_rid_o     (s_rid_o),
      .s_rvalid_o  (s_rvalid_o),
      .s_rready_i  (s_rready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int seq;
      int t;
   } req_t;

   req_t q[$];
   int   m_seq  = 0;
   int   cyc    = 0;
   int   passed = 0;
   int   total  = 0;

   function automatic int lat(input int id);
      int l;
      l = LAT_BASE + (15 - id) * LAT_STEP;
      return (l > 255) ? 255 : l;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_beat();
      int idx;
      int first;
      idx   = -1;
      first = -1;
      foreach (q[i]) if (idx < 0 && q[i].seq == int'(s_rdata_o)) idx = i;
      chk("beat_known", 32'(idx >= 0), 1);
      if (idx >= 0) begin
         foreach (q[i]) if (first < 0 && q[i].id == int'(s_rid_o)) first = i;
         chk("beat_id", 32'(s_rid_o), 32'(q[idx].id));
         chk("beat_same_id_order", 32'(first), 32'(idx));
         chk("beat_latency", 32'(cyc >= q[idx].t + lat(q[idx].id) + 1), 1);
         q.delete(idx);
      end
   endtask

   task automatic tick();
      logic       pa, pv, pr;
      logic [3:0] pid, prid;
      logic [7:0] prd;
      pa   = s_arvalid_i && s_arready_o;
      pid  = s_arid_i;
      pv   = s_rvalid_o;
      pr   = s_rready_i;
      prid = s_rid_o;
      prd  = s_rdata_o;
      @(posedge clk);
      #1;
      cyc++;
      if (pa) begin
         q.push_back('{int'(pid), m_seq, cyc});
         m_seq = (m_seq + 1) % 256;
      end
      if (pv && !pr) begin
         chk("stall_rvalid", 32'(s_rvalid_o), 1);
         chk("stall_rid", 32'(s_rid_o), 32'(prid));
         chk("stall_rdata", 32'(s_rdata_o), 32'(prd));
      end else if (s_rvalid_o) begin
         check_beat();
      end
      chk("arready_occupancy", 32'(s_arready_o), 32'(q.size() < DEPTH));
   endtask

   task automatic wait_rvalid();
      int n;
      n = 0;
      while (!s_rvalid_o && n < 300) begin
         tick();
         n++;
      end
      chk("wait_rvalid", 32'(s_rvalid_o), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_arvalid_i = 1'b0;
      #1;
      chk("rst_rvalid", 32'(s_rvalid_o), 0);
      chk("rst_arready", 32'(s_arready_o), 0);
      chk("rst_rid", 32'(s_rid_o), 0);
      chk("rst_rdata", 32'(s_rdata_o), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_seq = 0;
      #1;
      chk("post_rst_arready", 32'(s_arready_o), 1);
   endtask

   initial begin
      int         ar_cyc;
      int         ok;
      logic [31:0] d5;

      @(posedge clk);
      #1;
      do_reset();

      // single AR id=3, L=14
      s_rready_i = 1'b1;
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd3;
      tick();
      ar_cyc = cyc;
      s_arvalid_i = 1'b0;
      wait_rvalid();
      chk("t1_latency", 32'(cyc - ar_cyc), 15);
      chk("t1_rid", 32'(s_rid_o), 3);
      chk("t1_rdata", 32'(s_rdata_o), 0);
      tick();
      chk("t1_one_beat", 32'(s_rvalid_o), 0);

      // id=0 then id=15 back to back
      do_reset();
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd0;
      tick();
      ar_cyc = cyc;
      s_arid_i = 4'd15;
      tick();
      s_arvalid_i = 1'b0;
      wait_rvalid();
      chk("t2_first_time", 32'(cyc - ar_cyc), 4);
      chk("t2_first_rid", 32'(s_rid_o), 15);
      chk("t2_first_rdata", 32'(s_rdata_o), 1);
      tick();
      wait_rvalid();
      chk("t2_second_time", 32'(cyc - ar_cyc), 18);
      chk("t2_second_rid", 32'(s_rid_o), 0);
      chk("t2_second_rdata", 32'(s_rdata_o), 0);
      tick();

      // three same-ID requests behind a long stall
      do_reset();
      s_rready_i = 1'b0;
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd5;
      repeat (3) tick();
      s_arvalid_i = 1'b0;
      repeat (40) tick();
      chk("t3_stalled_valid", 32'(s_rvalid_o), 1);
      s_rready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_rvalid();
         chk("t3_rid", 32'(s_rid_o), 5);
         chk("t3_rdata_order", 32'(s_rdata_o), 32'(i));
         tick();
      end
      chk("t3_done", 32'(s_rvalid_o), 0);

      // fill all slots, fifth request waits for a free slot
      do_reset();
      s_rready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_arvalid_i = 1'b1;
         s_arid_i = 4'(i);
         chk("t4_arready_free", 32'(s_arready_o), 1);
         tick();
      end
      s_arid_i = 4'd5;
      chk("t4_full", 32'(s_arready_o), 0);
      ok = 0;
      for (int n = 0; n < 100; n++) begin
         if (s_arready_o) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk("t4_reopen", 32'(ok), 1);
      chk("t4_reopen_with_beat", 32'(s_rvalid_o), 1);
      d5 = 32'hffff_ffff;
      tick();
      s_arvalid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_rvalid();
         if (s_rid_o == 4'd5) d5 = 32'(s_rdata_o);
         tick();
      end
      chk("t4_fifth_rdata", d5, 4);

      // stalled output holds while another beat becomes eligible
      do_reset();
      s_rready_i = 1'b0;
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd15;
      tick();
      s_arid_i = 4'd14;
      tick();
      s_arvalid_i = 1'b0;
      wait_rvalid();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t5_hold_rid", 32'(s_rid_o), 15);
         chk("t5_hold_rdata", 32'(s_rdata_o), 0);
      end
      s_rready_i = 1'b1;
      wait_rvalid();
      chk("t5_first_rid", 32'(s_rid_o), 15);
      tick();
      wait_rvalid();
      chk("t5_second_rid", 32'(s_rid_o), 14);
      chk("t5_second_rdata", 32'(s_rdata_o), 1);
      tick();
      chk("t5_done", 32'(s_rvalid_o), 0);

      // reset while requests pend and a beat is presented
      s_rready_i = 1'b0;
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd15;
      tick();
      s_arid_i = 4'd0;
      tick();
      s_arid_i = 4'd1;
      tick();
      s_arvalid_i = 1'b0;
      wait_rvalid();
      do_reset();
      s_rready_i = 1'b1;
      s_arvalid_i = 1'b1;
      s_arid_i = 4'd2;
      tick();
      s_arvalid_i = 1'b0;
      wait_rvalid();
      chk("t6_rid", 32'(s_rid_o), 2);
      chk("t6_rdata", 32'(s_rdata_o), 0);
      tick();

      // randomized traffic checked against the request scoreboard
      do_reset();
      for (int n = 0; n < 1200; n++) begin
         s_arvalid_i = 1'($urandom_range(0, 1));
         s_arid_i    = (n < 600) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(13, 15));
         s_rready_i  = ($urandom_range(0, 9) < 7);
         tick();
      end
      s_arvalid_i = 1'b0;
      s_rready_i  = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if (q.size() == 0 && !s_rvalid_o) break;
         tick();
      end
      chk("drain_empty", 32'(q.size()), 0);
      chk("drain_rvalid", 32'(s_rvalid_o), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
